// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider: one restoring quotient bit per cycle,
// then a single normalise/round/special-case cycle that registers the result.
module fp_div #(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic        busy,
  output logic        done,
  output logic [31:0] otp,
  output logic        overflow,
  output logic        underflow,
  output logic        exception,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  localparam int CW = $clog2(ITER + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   a, b;
  logic [24:0]   r;
  logic [23:0]   d;
  logic [24:0]   q;
  logic [24:0]   r_sub;
  logic          ge;

  logic              sign;
  logic [7:0]        e1, e2;
  logic [22:0]       mant;
  logic              sticky;
  logic [23:0]       summ;
  logic signed [9:0] e_raw, e_fin;
  logic [22:0]       m_fin;
  logic [31:0]       res;
  logic              res_ovf, res_unf, res_exc, res_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DIV;
      DIV:     if (cnt == CW'(ITER - 1)) state_nx = NORM;
      NORM:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // R stays below 2*D, so the shifted remainder always fits in 25 bits.
  assign r_sub = r - {1'b0, d};
  assign ge    = (r >= {1'b0, d});

  always_comb begin
    sign   = a[31] ^ b[31];
    e1     = a[30:23];
    e2     = b[30:23];
    if (q[24]) begin
      mant   = q[23:1];
      sticky = q[0] | (r != '0);
      e_raw  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
    end else begin
      mant   = q[22:0];
      sticky = (r != '0);
      e_raw  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd126;
    end
    summ  = {1'b0, mant} + {23'd0, sticky};
    e_fin = e_raw;
    m_fin = summ[22:0];
    if (summ[23]) begin
      m_fin = '0;
      e_fin = e_raw + 10'sd1;
    end

    res     = {sign, e_fin[7:0], m_fin};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_exc = 1'b0;
    res_dbz = 1'b0;
    if (e1 == 8'hFF || e2 == 8'hFF) begin
      res     = 32'h7FC0_0000;
      res_exc = 1'b1;
    end else if (e2 == 8'h00) begin
      res     = {sign, 8'hFF, 23'h0};
      res_dbz = 1'b1;
    end else if (e1 == 8'h00) begin
      res = {sign, 31'h0};
    end else if (e_fin >= 10'sd255) begin
      res     = {sign, 8'hFF, 23'h0};
      res_ovf = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      res     = {sign, 8'h00, 23'h0};
      res_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      a           <= '0;
      b           <= '0;
      r           <= '0;
      d           <= '0;
      q           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      otp         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      exception   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a    <= input1;
          b    <= input2;
          r    <= {2'b01, input1[22:0]};
          d    <= {1'b1, input2[22:0]};
          q    <= '0;
          cnt  <= '0;
          busy <= 1'b1;
        end
        DIV: begin
          q   <= {q[23:0], ge};
          r   <= ge ? {r_sub[23:0], 1'b0} : {r[23:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          otp         <= res;
          overflow    <= res_ovf;
          underflow   <= res_unf;
          exception   <= res_exc;
          div_by_zero <= res_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed vectors push expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_fp_div;

  logic        clk, rst_n, start;
  logic [31:0] input1, input2;
  logic        busy, done;
  logic [31:0] otp;
  logic        overflow, underflow, exception, div_by_zero;

  fp_div #(.ITER(25)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .input1(input1), .input2(input2),
    .busy(busy), .done(done), .otp(otp),
    .overflow(overflow), .underflow(underflow),
    .exception(exception), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] otp;
    logic [3:0]  flags; // {overflow, underflow, exception, div_by_zero}
    int          edge_no;
    int          id;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_otp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: one done pulse consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("otp", e.id, otp, e.otp);
        chk("flags", e.id, {28'd0, overflow, underflow, exception, div_by_zero}, {28'd0, e.flags});
        chk("latency_edge", e.id, edge_cnt, e.edge_no);
        chk("busy_at_done", e.id, {31'd0, busy}, 32'd0);
        done_cnt++;
      end
    end
  end

  task automatic wait_done(input int id, input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout (vector %0d): got %0d dones, expected %0d", id, done_cnt, target);
    end
  endtask

  // Issue one divide; returns k, the edge that sampled start.
  task automatic issue(input int id, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eo, input logic [3:0] ef, input bit track, output int k);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    input1 = x;
    input2 = y;
    @(negedge clk);
    k = edge_cnt;
    start  = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
    if (track) begin
      e.otp = eo; e.flags = ef; e.edge_no = k + 26; e.id = id;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("busy_during_op", id, {31'd0, busy}, 32'd1);
    chk("otp_held_while_busy", id, otp, last_otp);
  endtask

  task automatic run(input int id, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eo, input logic [3:0] ef);
    int k;
    int tgt;
    tgt = done_cnt + 1;
    issue(id, x, y, eo, ef, 1'b1, k);
    wait_done(id, tgt);
    last_otp = eo;
    @(negedge clk);
    chk("otp_held_after_done", id, otp, eo);
  endtask

  initial begin
    int k;
    int tgt;
    rst_n = 1'b0; start = 1'b0; input1 = '0; input2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 0, {31'd0, busy}, 32'd0);
    chk("reset_done", 0, {31'd0, done}, 32'd0);
    chk("reset_otp", 0, otp, 32'd0);
    chk("reset_flags", 0, {28'd0, overflow, underflow, exception, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1,  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000); // 6/2
    run(2,  32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000); // 1/3
    run(3,  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001); // x/0
    run(4,  32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000); // 0/x
    run(5,  32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b1000); // overflow
    run(6,  32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 4'b0100); // underflow
    run(7,  32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0010); // inf dividend
    run(8,  32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000); // -6/2
    run(9,  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000); // 1/1
    run(10, 32'h3F7F_FFFF, 32'h3F80_0000, 32'h3F7F_FFFF, 4'b0000); // exact, no round
    run(11, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001); // 0/0: dbz wins
    run(12, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0010); // exception wins
    run(13, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0000); // -0/x

    // Second start at k+5 must be ignored.
    tgt = done_cnt + 1;
    issue(14, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b1, k);
    while (edge_cnt < k + 4) @(negedge clk);
    start = 1'b1; input1 = 32'h3F80_0000; input2 = 32'h4040_0000;
    @(negedge clk);
    start = 1'b0;
    wait_done(14, tgt);
    last_otp = 32'h4040_0000;
    repeat (30) @(negedge clk);
    chk("single_done_after_ignored_start", 14, done_cnt, tgt);

    // Reset mid-operation discards it.
    issue(15, 32'h3F80_0000, 32'h4040_0000, 32'h0, 4'b0000, 1'b0, k);
    while (edge_cnt < k + 9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 15, {31'd0, busy}, 32'd0);
    chk("abort_otp", 15, otp, 32'd0);
    chk("abort_done", 15, {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_otp = '0;
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", 15, done_cnt, tgt);

    run(16, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000);

    @(negedge clk);
    chk("scoreboard_empty", 0, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
